instr_fetch_unit: RTL

Instruction fetch stage feeding the decoder: holds the fetch program counter, issues in-order word requests to instruction memory, and buffers returned words with their PCs in a small queue. Decode consumes `{pc, instr}` pairs over a valid/ready handshake. A redirect from execute or branch resolution flushes everything in flight and restarts fetch at the new PC.

---
 rtl/riscv_fetch_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 42 ++++
 rtl/instr_fetch_unit_queue.sv | 80 ++++++++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fetch_pkg
//  Description : Shared widths, constants and the fetch queue entry type.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch: the word's PC, its instruction and whether the
    // memory response for it has arrived yet.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Redirect, instruction-memory and decode-side signals of the
//                fetch stage. master = fetch unit, slave = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if;
    import riscv_fetch_pkg::*;

    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_rsp_valid;
    logic [INSTR_W-1:0]  imem_rsp_data;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [INSTR_W-1:0]  out_instr;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_ready,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_ready,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instr
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Circular buffer of fetch entries. Entries are allocated at
//                request time, filled in order as responses return and popped
//                from the head by decode. Flush invalidates everything.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   flush,
    input  wire logic                   alloc,
    input  wire logic [XLEN-1:0]        alloc_pc,
    input  wire logic                   fill,
    input  wire logic [INSTR_W-1:0]     fill_instr,
    input  wire logic                   pop,
    output fetch_entry_t                head,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [$clog2(DEPTH):0]      unfilled
);

    localparam int PW = $clog2(DEPTH);
    localparam int QW = PW + 1;

    fetch_entry_t   entries [DEPTH];
    logic [PW-1:0]  alloc_ptr;
    logic [PW-1:0]  fill_ptr;
    logic [PW-1:0]  head_ptr;

    // Pointers wrap naturally because DEPTH is a power of two. The alloc,
    // fill and pop slots never coincide: alloc targets a free slot, fill an
    // allocated-unfilled one and pop a filled one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occupancy <= '0;
            unfilled  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occupancy <= '0;
            unfilled  <= '0;
        end else begin
            if (alloc) begin
                entries[alloc_ptr].pc     <= alloc_pc;
                entries[alloc_ptr].filled <= 1'b0;
                alloc_ptr                 <= alloc_ptr + 1'b1;
            end
            if (fill) begin
                entries[fill_ptr].instr  <= fill_instr;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + 1'b1;
            end
            if (pop) begin
                entries[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + 1'b1;
            end
            occupancy <= occupancy + QW'(alloc) - QW'(pop);
            unfilled  <= unfilled  + QW'(alloc) - QW'(fill);
        end
    end

    assign head = entries[head_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage. Owns the fetch PC, gates in-order requests to
//                instruction memory against queue space, buffers returned
//                words for decode and discards responses orphaned by a
//                redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instr_fetch_unit_if.master  bus
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    unfilled;
    logic [CW:0]      inflight;
    logic [CW:0]      drop_seed;
    logic             req_fire;
    logic             pop_fire;
    logic             rsp_drop;
    logic             rsp_fill;
    fetch_entry_t     head;
    logic             unused_redirect_lsb;

    // Requests are suppressed in reset and in a redirect cycle so that the
    // new target is the first address issued after the flush.
    assign bus.imem_req_valid = reset && (occupancy < DEPTH_C) && !bus.redirect_valid;
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign pop_fire = bus.out_valid && bus.out_ready;

    // Stale responses are consumed first; a response with nothing pending
    // at all is ignored.
    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = bus.imem_rsp_valid && (drop_cnt == '0) && (unfilled != '0);

    assign inflight  = {1'b0, unfilled} + {1'b0, drop_cnt};
    assign drop_seed = inflight - {{CW{1'b0}}, bus.imem_rsp_valid};

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    fetch_queue #(
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .alloc      (req_fire),
        .alloc_pc   (fetch_pc),
        .fill       (rsp_fill),
        .fill_instr (bus.imem_rsp_data),
        .pop        (pop_fire),
        .head       (head),
        .occupancy  (occupancy),
        .unfilled   (unfilled)
    );

    assign bus.out_valid = head.filled;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

    // Fetch PC: redirect target wins, otherwise step one word per accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // Count of responses still owed by memory for flushed requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (bus.redirect_valid) begin
            drop_cnt <= (inflight == '0) ? '0 : CW'(drop_seed);
        end else if (rsp_drop) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(bus.imem_rsp_valid && (inflight == '0)));

endmodule
`default_nettype wire
